// File: rtl/i2c_host_master.sv
// Single-master I2C controller: one-byte register writes and reads to a 7-bit slave address.
// Optional macro I2C_MASTER_STRETCH_EN: wait for the real SCL at every low-to-released quarter.
module i2c_host_master #(
    parameter int QTR = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam logic [7:0] QTR_M1 = 8'(QTR - 1);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rega;
        logic [7:0] wdata;
    } cmd_t;

    state_t     state, state_nx;
    cmd_t       cmd_q;
    logic [7:0] div_q;
    logic [1:0] qtr_q;
    logic [3:0] bit_q;
    logic [1:0] byte_q;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       nack_q;
    logic [1:0] sda_sync;
    logic       sda_s;
    logic       accept;
    logic       stall;
    logic       sym_end;
    logic       scl_d, sda_d;

    assign sda_s  = sda_sync[1];
    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) sda_sync <= 2'b11;
        else        sda_sync <= {sda_sync[0], sda_i};
    end

`ifdef I2C_MASTER_STRETCH_EN
    logic [1:0] scl_sync;
    logic       rise_q;

    always_ff @(posedge clk) begin
        if (!rst_n) scl_sync <= 2'b11;
        else        scl_sync <= {scl_sync[0], scl_i};
    end

    // Quarters where SCL is released after being driven low; a slave may hold it.
    always_comb begin
        rise_q = 1'b0;
        unique case (state)
            TX_BYTE, RX_ACK, RX_BYTE, TX_NACK, STOP: rise_q = (qtr_q == 2'd2);
            RSTART:                                  rise_q = (qtr_q == 2'd1);
            default:                                 rise_q = 1'b0;
        endcase
    end

    assign stall = rise_q && (div_q == 8'd0) && !scl_sync[1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign sym_end = !stall && (div_q == QTR_M1) && (qtr_q == 2'd3);

    // Quarter sequencer, parked at zero outside a transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 8'd0;
            qtr_q <= 2'd0;
        end else if (state == IDLE || state == DONE) begin
            div_q <= 8'd0;
            qtr_q <= 2'd0;
        end else if (!stall) begin
            if (div_q == QTR_M1) begin
                div_q <= 8'd0;
                qtr_q <= qtr_q + 2'd1;
            end else begin
                div_q <= div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = START;
            START:   if (sym_end) state_nx = TX_BYTE;
            TX_BYTE: if (sym_end && bit_q == 4'd0) state_nx = RX_ACK;
            RX_ACK: begin
                if (sym_end) begin
                    if (sda_s) begin
                        state_nx = STOP;
                    end else begin
                        unique case (byte_q)
                            2'd0:    state_nx = TX_BYTE;
                            2'd1:    state_nx = cmd_q.rw ? RSTART : TX_BYTE;
                            default: state_nx = cmd_q.rw ? RX_BYTE : STOP;
                        endcase
                    end
                end
            end
            RSTART:  if (sym_end) state_nx = TX_BYTE;
            RX_BYTE: if (sym_end && bit_q == 4'd0) state_nx = TX_NACK;
            TX_NACK: if (sym_end) state_nx = STOP;
            STOP:    if (sym_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // byte_q: 0 = {dev,W}, 1 = reg, 2 = wdata (write) or {dev,R} (read)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            bit_q     <= 4'd0;
            byte_q    <= 2'd0;
            tx_sr     <= 8'd0;
            rx_sr     <= 8'd0;
            nack_q    <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_nack  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q  <= '{rw: cmd_rw, dev: cmd_dev_addr, rega: cmd_reg_addr, wdata: cmd_wdata};
                        byte_q <= 2'd0;
                        nack_q <= 1'b0;
                        rx_sr  <= 8'd0;
                    end
                end
                START: begin
                    if (sym_end) begin
                        tx_sr <= {cmd_q.dev, 1'b0};
                        bit_q <= 4'd7;
                    end
                end
                TX_BYTE: begin
                    if (sym_end) begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                        bit_q <= bit_q - 4'd1;
                    end
                end
                RX_ACK: begin
                    if (sym_end) begin
                        if (sda_s) begin
                            nack_q <= 1'b1;
                        end else begin
                            byte_q <= byte_q + 2'd1;
                            bit_q  <= 4'd7;
                            if (byte_q == 2'd0)                    tx_sr <= cmd_q.rega;
                            else if (byte_q == 2'd1 && !cmd_q.rw) tx_sr <= cmd_q.wdata;
                        end
                    end
                end
                RSTART: begin
                    if (sym_end) begin
                        tx_sr <= {cmd_q.dev, 1'b1};
                        bit_q <= 4'd7;
                    end
                end
                RX_BYTE: begin
                    if (sym_end) begin
                        rx_sr <= {rx_sr[6:0], sda_s};
                        bit_q <= bit_q - 4'd1;
                    end
                end
                STOP: begin
                    if (sym_end) begin
                        rsp_rdata <= (cmd_q.rw && !nack_q) ? rx_sr : 8'd0;
                        rsp_nack  <= nack_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line shape per symbol and quarter; 1 = pull low
    always_comb begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        unique case (state)
            START: begin
                sda_d = (qtr_q >= 2'd2);
            end
            TX_BYTE: begin
                scl_d = (qtr_q < 2'd2);
                sda_d = ~tx_sr[7];
            end
            RX_ACK, RX_BYTE, TX_NACK: begin
                scl_d = (qtr_q < 2'd2);
            end
            RSTART: begin
                scl_d = (qtr_q == 2'd0);
                sda_d = (qtr_q >= 2'd2);
            end
            STOP: begin
                scl_d = (qtr_q < 2'd2);
                sda_d = (qtr_q < 2'd3);
            end
            default: ;
        endcase
    end

    // Registered pad enables keep decode glitches off the bus
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            scl_oe    <= scl_d;
            sda_oe    <= sda_d;
            cmd_ready <= (state_nx == IDLE);
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_i2c_host_master.sv
// Directed bench for i2c_host_master with a bit-level I2C slave model at address 7'h48.
// With I2C_MASTER_STRETCH_EN defined, latencies become lower bounds and a stretch case is added.
module tb_i2c_host_master;

    localparam int QTR = 4;
    localparam logic [6:0] SL_ADDR = 7'h48;
    localparam int SYM = 4 * QTR;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr, cmd_wdata;
    logic       rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_rdata;
    logic       scl_i, sda_i, scl_oe, sda_oe;

    i2c_host_master #(.QTR(QTR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_rsp = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) n_rsp <= n_rsp + 1;
    end

    // Slave model
    logic       sl_sda_low = 1'b0;
    int         stretch_cnt = 0;
    logic       stretch_on = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    int         cnt = 0, nbytes = 0, ntot = 0, n_start = 0, n_stop = 0;
    logic [7:0] shreg = 8'h00;
    logic       reading = 1'b0, ack_en = 1'b0, rd_req = 1'b0, mst_ack = 1'b0;
    logic [7:0] log_b [0:63];

    wire scl_bus = !(scl_oe || stretch_cnt != 0);
    wire sda_bus = !(sda_oe || sl_sda_low);
    assign scl_i = scl_bus;
    assign sda_i = sda_bus;

    always @(posedge clk) begin
        scl_prev <= scl_bus;
        sda_prev <= sda_bus;
        if (stretch_cnt != 0) stretch_cnt <= stretch_cnt - 1;
        if (scl_prev && scl_bus && sda_prev && !sda_bus) begin
            n_start <= n_start + 1; cnt <= 0; nbytes <= 0; reading <= 1'b0; sl_sda_low <= 1'b0;
        end else if (scl_prev && scl_bus && !sda_prev && sda_bus) begin
            n_stop <= n_stop + 1; cnt <= 0; reading <= 1'b0; sl_sda_low <= 1'b0;
        end else if (!scl_prev && scl_bus) begin
            cnt <= cnt + 1;
            if (cnt < 8) shreg <= {shreg[6:0], sda_bus};
            if (cnt == 7 && !reading) begin
                if (ntot < 64) log_b[ntot] <= {shreg[6:0], sda_bus};
                ntot   <= ntot + 1;
                nbytes <= nbytes + 1;
                if (nbytes == 0) begin
                    ack_en <= (shreg[6:0] == SL_ADDR);
                    rd_req <= sda_bus;
                end
            end
            if (cnt == 8 && reading) mst_ack <= sda_bus;
        end else if (scl_prev && !scl_bus) begin
            sl_sda_low <= 1'b0;
            if (cnt == 8 && !reading) begin
                sl_sda_low <= ack_en;
                // hold SCL 50 clk beyond the master's own low half of the data-byte ACK
                if (stretch_on && nbytes == 3) stretch_cnt <= 2 * QTR + 50;
            end else if (cnt == 9) begin
                cnt <= 0;
                if (!reading && nbytes == 1 && rd_req && ack_en) begin
                    reading    <= 1'b1;
                    sl_sda_low <= !rd_byte[7];
                end else begin
                    reading <= 1'b0;
                end
            end else if (reading && cnt >= 1 && cnt <= 7) begin
                sl_sda_low <= !rd_byte[7 - cnt];
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat, input int base);
`ifdef I2C_MASTER_STRETCH_EN
        chk(tag, 32'(lat >= base), 32'd1);
`else
        chk(tag, lat, base);
`endif
    endtask

    task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, output int lat, output logic [7:0] rd,
                           output logic nk);
        int t0;
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        chk("ready_wait", cmd_ready, 1);
        t0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy", busy, 1);
        guard = 0;
        while (!rsp_valid && guard < 5000) begin @(negedge clk); guard++; end
        chk("rsp_arrived", rsp_valid, 1);
        lat = cyc - t0;
        rd  = rsp_rdata;
        nk  = rsp_nack;
    endtask

    int         lat, lat_plain, b, s, st, r0, guard, acc, t_acc1, t_acc2, t_rsp1;
    logic [7:0] rd, rd_a;
    logic       nk, nk_a;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev_addr = 7'h00; cmd_reg_addr = 8'h00; cmd_wdata = 8'h00;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_nack", rsp_nack, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);

        // Write 48/03/A5
        b = ntot; s = n_stop;
        run_cmd(1'b0, 7'h48, 8'h03, 8'hA5, lat, rd, nk);
        lat_plain = lat;
        chk_lat("wr_lat", lat, 29 * SYM + 1);
        chk("wr_nack", nk, 0);
        chk("wr_rdata", rd, 0);
        repeat (3) @(negedge clk);
        chk("wr_nbytes", ntot - b, 3);
        chk("wr_b0", log_b[b], 8'h90);
        chk("wr_b1", log_b[b + 1], 8'h03);
        chk("wr_b2", log_b[b + 2], 8'hA5);
        chk("wr_stop", n_stop - s, 1);
        chk("wr_idle_ready", cmd_ready, 1);

        // Read 48/F1, slave returns 5C
        rd_byte = 8'h5C;
        b = ntot; s = n_stop; st = n_start;
        run_cmd(1'b1, 7'h48, 8'hF1, 8'hEE, lat, rd, nk);
        chk_lat("rd_lat", lat, 39 * SYM + 1);
        chk("rd_rdata", rd, 8'h5C);
        chk("rd_nack", nk, 0);
        repeat (5) @(negedge clk);
        chk("rd_nbytes", ntot - b, 3);
        chk("rd_b0", log_b[b], 8'h90);
        chk("rd_b1", log_b[b + 1], 8'hF1);
        chk("rd_b2", log_b[b + 2], 8'h91);
        chk("rd_starts", n_start - st, 2);
        chk("rd_mst_nack", mst_ack, 1);
        chk("rd_stop", n_stop - s, 1);
        chk("rd_hold", rsp_rdata, 8'h5C);

        // Absent slave 7'h10: NACK at first ACK slot
        b = ntot; s = n_stop;
        run_cmd(1'b0, 7'h10, 8'h03, 8'h55, lat, rd, nk);
        chk_lat("nk_lat", lat, (1 + 9 * 1 + 1) * SYM + 1);
        chk("nk_nack", nk, 1);
        chk("nk_rdata", rd, 0);
        repeat (3) @(negedge clk);
        chk("nk_nbytes", ntot - b, 1);
        chk("nk_b0", log_b[b], 8'h20);
        chk("nk_stop", n_stop - s, 1);

        // Back-to-back: cmd_valid held high across two commands
        rd_byte = 8'hC3;
        b = ntot; r0 = n_rsp;
        acc = 0; guard = 0; t_rsp1 = -1; t_acc1 = 0; t_acc2 = 0; rd_a = 8'h00; nk_a = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h48; cmd_reg_addr = 8'h05; cmd_wdata = 8'h3C;
        while (acc < 2 && guard < 3000) begin
            if (cmd_valid && cmd_ready) begin
                if (acc == 0) t_acc1 = cyc; else t_acc2 = cyc;
                acc++;
            end
            if (rsp_valid && t_rsp1 < 0) begin t_rsp1 = cyc; rd_a = rsp_rdata; nk_a = rsp_nack; end
            @(negedge clk);
            if (acc == 1) begin cmd_rw = 1'b1; cmd_reg_addr = 8'hF0; cmd_wdata = 8'h00; end
            guard++;
        end
        cmd_valid = 1'b0;
        chk("q_accepts", acc, 2);
        chk("q_gap", t_acc2 - t_rsp1, 1);
        chk_lat("q_lat_a", t_rsp1 - t_acc1, 29 * SYM + 1);
        chk("q_nack_a", nk_a, 0);
        chk("q_rdata_a", rd_a, 0);
        guard = 0;
        while (!rsp_valid && guard < 5000) begin @(negedge clk); guard++; end
        chk("q_rsp_b", rsp_valid, 1);
        chk("q_rdata_b", rsp_rdata, 8'hC3);
        chk("q_nack_b", rsp_nack, 0);
        repeat (30) @(negedge clk);
        chk("q_rsp_count", n_rsp - r0, 2);
        chk("q_nbytes", ntot - b, 6);
        chk("q_b1", log_b[b + 1], 8'h05);
        chk("q_b2", log_b[b + 2], 8'h3C);
        chk("q_b4", log_b[b + 4], 8'hF0);
        chk("q_b5", log_b[b + 5], 8'h91);

        // Reset during bit 3 of the reg byte
        r0 = n_rsp;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev_addr = 7'h48; cmd_reg_addr = 8'h22; cmd_wdata = 8'h77;
        guard = 0;
        while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (14 * SYM + 2) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_scl_oe", scl_oe, 0);
        chk("mid_sda_oe", sda_oe, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_ready", cmd_ready, 1);
        chk("mid_busy", busy, 0);
        repeat (20) @(negedge clk);
        chk("mid_no_rsp", n_rsp - r0, 0);
        b = ntot;
        run_cmd(1'b0, 7'h48, 8'h0A, 8'h5A, lat, rd, nk);
        chk_lat("post_lat", lat, 29 * SYM + 1);
        chk("post_nack", nk, 0);
        repeat (3) @(negedge clk);
        chk("post_nbytes", ntot - b, 3);
        chk("post_b1", log_b[b + 1], 8'h0A);
        chk("post_b2", log_b[b + 2], 8'h5A);

`ifdef I2C_MASTER_STRETCH_EN
        stretch_on = 1'b1;
        b = ntot;
        run_cmd(1'b0, 7'h48, 8'h07, 8'h11, lat, rd, nk);
        stretch_on = 1'b0;
        chk("str_lat", 32'(lat >= lat_plain + 50), 32'd1);
        chk("str_nack", nk, 0);
        repeat (3) @(negedge clk);
        chk("str_nbytes", ntot - b, 3);
        chk("str_b2", log_b[b + 2], 8'h11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
